// File: rtl/out_port_tx.sv
// Output-port transmit stage: buffers the SRAM read stream in a packet-tagged FIFO,
// checks CRC-32 per packet and forwards words on a valid/ready interface.
module out_port_tx #(
   parameter int DWIDTH       = 32,
   parameter int FIFO_AWIDTH  = 6,
   parameter int AFULL_MARGIN = 20
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rd_sop,
   input  logic              i_rd_vld,
   input  logic [DWIDTH-1:0] i_rd_data,
   input  logic              i_rd_eop,
   input  logic              i_crc_vld,
   input  logic [DWIDTH-1:0] i_crc,
   output logic              o_tx_vld,
   input  logic              i_tx_rdy,
   output logic [DWIDTH-1:0] o_tx_data,
   output logic              o_tx_sop,
   output logic              o_tx_eop,
   output logic              o_tx_err,
   output logic              o_buf_afull,
   output logic              o_ovf,
   output logic [15:0]       o_pkt_cnt,
   output logic [15:0]       o_err_cnt
);

   localparam int                DEPTH     = 1 << FIFO_AWIDTH;
   localparam logic [FIFO_AWIDTH:0] FULL_CNT  = (FIFO_AWIDTH+1)'(DEPTH);
   localparam logic [FIFO_AWIDTH:0] LAST_CNT  = (FIFO_AWIDTH+1)'(DEPTH - 1);
   localparam logic [FIFO_AWIDTH:0] AFULL_CNT = (FIFO_AWIDTH+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [DWIDTH-1:0] CRC_POLY  = 32'h04C1_1DB7;
   localparam logic [DWIDTH-1:0] CRC_INIT  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, PKT, DISCARD} state_t;

   typedef struct packed {
      logic              err;
      logic              eop;
      logic              sop;
      logic [DWIDTH-1:0] data;
   } entry_t;

   // Non-reflected CRC-32, MSB of the word first.
   function automatic logic [DWIDTH-1:0] crc_next(input logic [DWIDTH-1:0] crc_in,
                                                  input logic [DWIDTH-1:0] word);
      logic [DWIDTH-1:0] c;
      logic              fb;
      c = crc_in;
      for (int i = DWIDTH-1; i >= 0; i--) begin
         fb = c[DWIDTH-1] ^ word[i];
         c  = {c[DWIDTH-2:0], 1'b0};
         if (fb) c = c ^ CRC_POLY;
      end
      return c;
   endfunction

   state_t                 state, state_nx;
   logic [DWIDTH-1:0]      crc, crc_upd, crc_final;
   logic                   pkt_err;
   logic [DWIDTH-1:0]      hold_data;
   logic                   hold_vld, sop_pending;
   entry_t                 skid, skid_nx;
   logic                   skid_vld, skid_set;
   logic                   wr_req, eop_cycle, start_pkt, crc_load, hold_load;
   entry_t                 wr_ent, fifo_wr;
   logic                   fifo_we, ovf_set, pop;
   entry_t                 mem [DEPTH];
   logic [FIFO_AWIDTH-1:0] wptr, rptr;
   logic [FIFO_AWIDTH:0]   count;

   assign crc_upd   = crc_next(crc, i_rd_data);
   assign crc_final = i_rd_vld ? crc_upd : crc;
   assign pkt_err   = !(i_crc_vld && (crc_final == i_crc));
   assign pop       = (count != '0) && (!o_tx_vld || i_tx_rdy);

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nx  = state;
      wr_req    = 1'b0;
      wr_ent    = '0;
      eop_cycle = 1'b0;
      start_pkt = 1'b0;
      crc_load  = 1'b0;
      hold_load = 1'b0;
      skid_set  = 1'b0;
      skid_nx   = '0;
      if (skid_vld) begin
         wr_req = 1'b1;
         wr_ent = skid;
      end
      unique case (state)
         IDLE: begin
            if (i_rd_sop) begin
               start_pkt = 1'b1;
               state_nx  = PKT;
            end
         end
         PKT: begin
            if (i_rd_sop) begin
               // Abort: close the open packet as errored and restart.
               if (hold_vld) begin
                  wr_req = 1'b1;
                  wr_ent = '{1'b1, 1'b1, sop_pending, hold_data};
               end
               start_pkt = 1'b1;
            end else if (i_rd_eop) begin
               eop_cycle = 1'b1;
               state_nx  = IDLE;
               if (i_rd_vld) begin
                  wr_req = 1'b1;
                  if (hold_vld) begin
                     wr_ent   = '{1'b0, 1'b0, sop_pending, hold_data};
                     skid_set = 1'b1;
                     skid_nx  = '{pkt_err, 1'b1, 1'b0, i_rd_data};
                  end else begin
                     wr_ent = '{pkt_err, 1'b1, sop_pending, i_rd_data};
                  end
               end else if (hold_vld) begin
                  wr_req = 1'b1;
                  wr_ent = '{pkt_err, 1'b1, sop_pending, hold_data};
               end
            end else if (i_rd_vld) begin
               crc_load  = 1'b1;
               hold_load = 1'b1;
               if (hold_vld) begin
                  wr_req = 1'b1;
                  wr_ent = '{1'b0, 1'b0, sop_pending, hold_data};
               end
            end
         end
         DISCARD: begin
            if (i_rd_eop) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Admission on pre-edge occupancy; the last free slot is reserved for an eop.
      fifo_we = wr_req;
      fifo_wr = wr_ent;
      ovf_set = 1'b0;
      if (wr_req && count == FULL_CNT) begin
         fifo_we = 1'b0;
         ovf_set = 1'b1;
      end else if (wr_req && !wr_ent.eop && count == LAST_CNT) begin
         fifo_wr.eop = 1'b1;
         fifo_wr.err = 1'b1;
         ovf_set     = 1'b1;
      end
      if (ovf_set) begin
         skid_set = 1'b0;
         if (state == PKT && !eop_cycle) state_nx = DISCARD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         crc         <= '0;
         hold_data   <= '0;
         hold_vld    <= 1'b0;
         sop_pending <= 1'b0;
         skid        <= '0;
         skid_vld    <= 1'b0;
      end else begin
         if (start_pkt)     crc <= CRC_INIT;
         else if (crc_load) crc <= crc_upd;
         if (start_pkt || eop_cycle) hold_vld <= 1'b0;
         else if (hold_load)         hold_vld <= 1'b1;
         if (hold_load) hold_data <= i_rd_data;
         if (start_pkt)   sop_pending <= 1'b1;
         else if (wr_req) sop_pending <= 1'b0;
         skid_vld <= skid_set;
         if (skid_set) skid <= skid_nx;
      end
   end

   // NOTE: the storage array is not reset; pointers and count define its contents.
   always_ff @(posedge i_clk) begin
      if (fifo_we) mem[wptr] <= fifo_wr;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         o_tx_vld    <= 1'b0;
         o_tx_data   <= '0;
         o_tx_sop    <= 1'b0;
         o_tx_eop    <= 1'b0;
         o_tx_err    <= 1'b0;
         o_buf_afull <= 1'b0;
         o_ovf       <= 1'b0;
         o_pkt_cnt   <= '0;
         o_err_cnt   <= '0;
      end else begin
         if (fifo_we) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({fifo_we, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            o_tx_vld <= 1'b1;
            {o_tx_err, o_tx_eop, o_tx_sop, o_tx_data} <= mem[rptr];
         end else if (i_tx_rdy) begin
            o_tx_vld <= 1'b0;
         end
         o_buf_afull <= (count >= AFULL_CNT);
         if (ovf_set) o_ovf <= 1'b1;
         if (fifo_we && fifo_wr.eop && o_pkt_cnt != 16'hFFFF)
            o_pkt_cnt <= o_pkt_cnt + 1'b1;
         if (fifo_we && fifo_wr.eop && fifo_wr.err && o_err_cnt != 16'hFFFF)
            o_err_cnt <= o_err_cnt + 1'b1;
      end
   end

endmodule
